// File: rtl/audio_framer.sv
// Audio front end: first-order pre-emphasis into a circular buffer, then overlapping frames
// of FRAME_LEN samples read out as a one-sample-per-cycle burst every HOP_LEN input samples.
module audio_framer #(
  parameter int unsigned        FRAME_LEN    = 256,
  parameter int unsigned        HOP_LEN      = 128,
  parameter logic signed [15:0] PREEMPH_COEF = 16'sd31785
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] audio_sample,
  input  logic               sample_valid,
  input  logic               overrun_clr,
  output logic signed [15:0] frame_sample,
  output logic               frame_valid,
  output logic               frame_start,
  output logic               frame_end,
  output logic               overrun
);

  localparam int unsigned DEPTH = FRAME_LEN + HOP_LEN;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned AW1   = AW + 1;
  localparam int unsigned CW    = $clog2(FRAME_LEN);

  localparam logic [AW-1:0] LastAddr  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DepthW    = AW1'(DEPTH);
  localparam logic [AW:0]   HopW      = AW1'(HOP_LEN);
  localparam logic [CW-1:0] FrameLast = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] HopLast   = CW'(HOP_LEN - 1);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
  logic               first_done_q, first_done_d;
  logic signed [15:0] x_prev_q, x_prev_d;
  logic               overrun_q, overrun_d;

  logic               s1_valid_q, s1_start_q, s1_end_q;
  logic               out_valid_q, out_start_q, out_end_q;
  logic signed [15:0] out_sample_q;
  logic [15:0]        rd_data_q;
  logic [15:0]        mem_q [DEPTH];

  logic signed [31:0] prod;
  logic signed [16:0] prod_sh;
  logic signed [16:0] diff;
  logic signed [15:0] y;
  logic [AW-1:0]      wr_ptr_nxt;
  logic [AW-1:0]      rd_ptr_nxt;
  logic [AW:0]        base_sum;
  logic [AW-1:0]      base;
  logic               trig;
  logic               rd_en;
  logic               ovr_set;

  // Pre-emphasis: y = x - ((a * x_prev) >>> 15), saturated to 16 bits.
  always_comb begin
    prod    = 32'(PREEMPH_COEF) * 32'(x_prev_q);
    prod_sh = 17'(prod >>> 15);
    diff    = 17'(audio_sample) - prod_sh;
    if (diff[16] != diff[15]) begin
      y = diff[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      y = diff[15:0];
    end
  end

  // Oldest of the last FRAME_LEN samples: (wr_ptr + 1 - FRAME_LEN) mod DEPTH.
  always_comb begin
    wr_ptr_nxt = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_nxt = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
    base_sum   = {1'b0, wr_ptr_nxt} + HopW;
    base       = (base_sum >= DepthW) ? AW'(base_sum - DepthW) : AW'(base_sum);
  end

  // Write side: fill counter until the first frame, hop counter afterwards.
  always_comb begin
    trig         = 1'b0;
    cnt_d        = cnt_q;
    first_done_d = first_done_q;
    wr_ptr_d     = wr_ptr_q;
    x_prev_d     = x_prev_q;
    if (sample_valid) begin
      wr_ptr_d = wr_ptr_nxt;
      x_prev_d = audio_sample;
      if (!first_done_q) begin
        if (cnt_q == FrameLast) begin
          trig         = 1'b1;
          first_done_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (cnt_q == HopLast) begin
        trig  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Read FSM; a trigger that lands while a burst is being issued is dropped.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rd_cnt_d = rd_cnt_q;
    rd_en    = 1'b0;
    ovr_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          state_d  = StRead;
          rd_ptr_d = base;
          rd_cnt_d = '0;
        end
      end
      StRead: begin
        rd_en    = 1'b1;
        rd_ptr_d = rd_ptr_nxt;
        rd_cnt_d = rd_cnt_q + 1'b1;
        ovr_set  = trig;
        if (rd_cnt_q == FrameLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (ovr_set) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      rd_cnt_q     <= '0;
      first_done_q <= 1'b0;
      x_prev_q     <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      first_done_q <= first_done_d;
      x_prev_q     <= x_prev_d;
      overrun_q    <= overrun_d;
    end
  end

  // Sample buffer with registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (sample_valid) begin
      mem_q[wr_ptr_q] <= y;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  // Two-stage flag pipeline aligned with the RAM read and the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_start_q   <= 1'b0;
      s1_end_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_start_q  <= 1'b0;
      out_end_q    <= 1'b0;
      out_sample_q <= '0;
    end else begin
      s1_valid_q  <= rd_en;
      s1_start_q  <= rd_en && (rd_cnt_q == '0);
      s1_end_q    <= rd_en && (rd_cnt_q == FrameLast);
      out_valid_q <= s1_valid_q;
      out_start_q <= s1_start_q;
      out_end_q   <= s1_end_q;
      if (s1_valid_q) begin
        out_sample_q <= rd_data_q;
      end
    end
  end

  assign frame_sample = out_sample_q;
  assign frame_valid  = out_valid_q;
  assign frame_start  = out_start_q;
  assign frame_end    = out_end_q;
  assign overrun      = overrun_q;

endmodule
